// File: rtl/postproc_pkg.sv
// Shared constants and stage payload type for the log-domain dynamic-range compressor.
package postproc_pkg;

    localparam int unsigned LOG_WIDTH      = 16;
    localparam int unsigned COMP_WIDTH     = 8;
    localparam int unsigned GAIN_WIDTH     = 12;
    localparam int unsigned GAIN_FRAC      = 8;
    localparam int unsigned GAIN_ONE       = 1 << GAIN_FRAC;
    localparam int unsigned CLIP_CNT_WIDTH = 16;
    localparam int unsigned PROD_WIDTH     = LOG_WIDTH + GAIN_WIDTH + 1;

    // Default-width stage payload; the top re-declares it against its own parameters.
    typedef struct packed {
        logic [PROD_WIDTH-1:0] data;
        logic [GAIN_WIDTH-1:0] gain;
        logic                  last;
        logic                  valid;
    } stage_t;

endpackage

// File: rtl/postproc_clamp.sv
// Arithmetic shift of the gained product back to integer scale, then clamp
// into the unsigned output range with low/high clip flags.
module postproc_clamp #(
    parameter int unsigned PROD_WIDTH = postproc_pkg::PROD_WIDTH,
    parameter int unsigned COMP_WIDTH = postproc_pkg::COMP_WIDTH,
    parameter int unsigned GAIN_FRAC  = postproc_pkg::GAIN_FRAC
) (
    input  logic signed [PROD_WIDTH-1:0] i_prod,
    output logic        [COMP_WIDTH-1:0] o_value,
    output logic                         o_clip_lo,
    output logic                         o_clip_hi
);
    import postproc_pkg::*;

    logic signed [PROD_WIDTH-1:0] w_sh;

    always_comb begin
        w_sh      = i_prod >>> GAIN_FRAC;
        o_clip_lo = w_sh[PROD_WIDTH-1];
        // Positive and any bit above the output range set means overflow.
        o_clip_hi = !w_sh[PROD_WIDTH-1] && (|w_sh[PROD_WIDTH-2:COMP_WIDTH]);
        if (o_clip_lo) begin
            o_value = '0;
        end else if (o_clip_hi) begin
            o_value = '1;
        end else begin
            o_value = w_sh[COMP_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/postproc_drc.sv
// Pipelined log-domain dynamic-range compressor, one sample per cycle, frame-latched floor/gain.
// Clip statistics counters are built only when POSTPROC_CLIP_STATS_EN is defined.
module postproc_drc #(
    parameter int unsigned LOG_WIDTH  = postproc_pkg::LOG_WIDTH,
    parameter int unsigned COMP_WIDTH = postproc_pkg::COMP_WIDTH,
    parameter int unsigned GAIN_WIDTH = postproc_pkg::GAIN_WIDTH,
    parameter int unsigned GAIN_FRAC  = postproc_pkg::GAIN_FRAC
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [LOG_WIDTH-1:0]                    log_in,
    input  logic                                    in_last,
    input  logic [LOG_WIDTH-1:0]                    floor_cfg,
    input  logic [GAIN_WIDTH-1:0]                   gain_cfg,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [COMP_WIDTH-1:0]                   comp_out,
    output logic                                    out_last,
    output logic [postproc_pkg::CLIP_CNT_WIDTH-1:0] clip_lo_cnt,
    output logic [postproc_pkg::CLIP_CNT_WIDTH-1:0] clip_hi_cnt
);
    import postproc_pkg::*;

    localparam int unsigned PW = LOG_WIDTH + GAIN_WIDTH + 1;

    typedef struct packed {
        logic [LOG_WIDTH:0]    data;
        logic [GAIN_WIDTH-1:0] gain;
        logic                  last;
        logic                  valid;
    } s1_t;

    logic                  w_adv;
    logic                  w_accept;
    logic [LOG_WIDTH-1:0]  w_floor;
    logic [GAIN_WIDTH-1:0] w_gain;
    logic [LOG_WIDTH:0]    w_diff;
    logic signed [PW-1:0]  w_diff_x;
    logic signed [PW-1:0]  w_gain_x;
    logic signed [PW-1:0]  w_prod;
    logic [COMP_WIDTH-1:0] w_clamp_val;
    logic                  w_clip_lo;
    logic                  w_clip_hi;

    logic                  r_first;
    logic [LOG_WIDTH-1:0]  r_floor;
    logic [GAIN_WIDTH-1:0] r_gain;
    s1_t                   r_s1;
    logic signed [PW-1:0]  r_s2_prod;
    logic                  r_s2_last;
    logic                  r_s2_valid;
    logic [COMP_WIDTH-1:0] r_s3_val;
    logic                  r_s3_lo;
    logic                  r_s3_hi;
    logic                  r_s3_last;
    logic                  r_s3_valid;
    logic                  r_out_valid;
    logic [COMP_WIDTH-1:0] r_comp;
    logic                  r_out_last;

    always_comb begin
        w_adv    = !r_out_valid || out_ready;
        w_accept = in_valid && w_adv;
        // A first beat uses the cfg it is latching, not the stale frame registers.
        w_floor  = r_first ? floor_cfg : r_floor;
        w_gain   = r_first ? gain_cfg  : r_gain;
        w_diff   = {1'b0, log_in} - {1'b0, w_floor};
        w_diff_x = {{GAIN_WIDTH{r_s1.data[LOG_WIDTH]}}, r_s1.data};
        w_gain_x = {{(LOG_WIDTH + 1){1'b0}}, r_s1.gain};
        w_prod   = w_diff_x * w_gain_x;
    end

    postproc_clamp #(
        .PROD_WIDTH (PW),
        .COMP_WIDTH (COMP_WIDTH),
        .GAIN_FRAC  (GAIN_FRAC)
    ) u_clamp (
        .i_prod    (r_s2_prod),
        .o_value   (w_clamp_val),
        .o_clip_lo (w_clip_lo),
        .o_clip_hi (w_clip_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first     <= 1'b1;
            r_floor     <= '0;
            r_gain      <= '0;
            r_s1        <= '0;
            r_s2_prod   <= '0;
            r_s2_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_val    <= '0;
            r_s3_lo     <= 1'b0;
            r_s3_hi     <= 1'b0;
            r_s3_last   <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_comp      <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_first) begin
                    r_floor <= floor_cfg;
                    r_gain  <= gain_cfg;
                end
                r_first <= in_last;
            end
            if (w_adv) begin
                r_s1.valid <= w_accept;
                if (w_accept) begin
                    r_s1.data <= w_diff;
                    r_s1.gain <= w_gain;
                    r_s1.last <= in_last;
                end
                r_s2_valid <= r_s1.valid;
                if (r_s1.valid) begin
                    r_s2_prod <= w_prod;
                    r_s2_last <= r_s1.last;
                end
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_s3_val  <= w_clamp_val;
                    r_s3_lo   <= w_clip_lo;
                    r_s3_hi   <= w_clip_hi;
                    r_s3_last <= r_s2_last;
                end
                r_out_valid <= r_s3_valid;
                if (r_s3_valid) begin
                    r_comp     <= r_s3_val;
                    r_out_last <= r_s3_last;
                end
            end
        end
    end

`ifdef POSTPROC_CLIP_STATS_EN
    logic [CLIP_CNT_WIDTH-1:0] r_lo_cnt;
    logic [CLIP_CNT_WIDTH-1:0] r_hi_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo_cnt <= '0;
            r_hi_cnt <= '0;
        end else if (w_adv && r_s3_valid) begin
            if (r_s3_lo && (r_lo_cnt != '1)) r_lo_cnt <= r_lo_cnt + 1'b1;
            if (r_s3_hi && (r_hi_cnt != '1)) r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    end

    assign clip_lo_cnt = r_lo_cnt;
    assign clip_hi_cnt = r_hi_cnt;
`else
    logic w_unused_clip;
    assign w_unused_clip = r_s3_lo ^ r_s3_hi;
    assign clip_lo_cnt   = '0;
    assign clip_hi_cnt   = '0;
`endif

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign comp_out  = r_comp;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_postproc_drc.sv
// Directed-vector bench for postproc_drc; clip counter expectations follow POSTPROC_CLIP_STATS_EN.
module tb_postproc_drc;
    import postproc_pkg::*;

`ifdef POSTPROC_CLIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] log_in = '0;
    logic        in_last = 1'b0;
    logic [15:0] floor_cfg = '0;
    logic [11:0] gain_cfg = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  comp_out;
    logic        out_last;
    logic [15:0] clip_lo_cnt;
    logic [15:0] clip_hi_cnt;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    postproc_drc dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .log_in      (log_in),
        .in_last     (in_last),
        .floor_cfg   (floor_cfg),
        .gain_cfg    (gain_cfg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .comp_out    (comp_out),
        .out_last    (out_last),
        .clip_lo_cnt (clip_lo_cnt),
        .clip_hi_cnt (clip_hi_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Present one beat and hold it until accepted; leaves in_valid high for back-to-back use.
    task automatic beat(input logic [15:0] lg, input bit last, input logic [15:0] flr,
                        input logic [11:0] gn, input logic [7:0] want);
        bit acc;
        int guard;
        in_valid  = 1'b1;
        log_in    = lg;
        in_last   = last;
        floor_cfg = flr;
        gain_cfg  = gn;
        exp_q.push_back('{d: want, l: last});
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0;
        guard    = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic stall5();
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            if (exp_q.size() != 0) check("stall_hold", {24'd0, comp_out}, {24'd0, exp_q[0].d});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {24'd0, comp_out}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("comp_out", {24'd0, comp_out}, {24'd0, mon_e.d});
                check("out_last", {31'd0, out_last}, {31'd0, mon_e.l});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] g1;
        g1 = 16'(GAIN_ONE);

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_comp_out", {24'd0, comp_out}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_lo_cnt", {16'd0, clip_lo_cnt}, 32'd0);
        check("rst_hi_cnt", {16'd0, clip_hi_cnt}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic mapping and three-cycle latency
        beat(16'h1050, 1'b1, 16'h1000, g1[11:0], 8'h50);
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency_valid_%0d", k), {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
        drain();
        check("noclip_lo", {16'd0, clip_lo_cnt}, 32'd0);
        check("noclip_hi", {16'd0, clip_hi_cnt}, 32'd0);

        // Clamp below and above range
        beat(16'h0F00, 1'b1, 16'h1000, g1[11:0], 8'h00);
        beat(16'h2000, 1'b1, 16'h1000, g1[11:0], 8'hFF);
        drain();
        check("clip_lo_cnt", {16'd0, clip_lo_cnt}, STATS ? 32'd1 : 32'd0);
        check("clip_hi_cnt", {16'd0, clip_hi_cnt}, STATS ? 32'd1 : 32'd0);

        // Half gain and zero gain
        beat(16'h1100, 1'b1, 16'h1000, 12'h080, 8'h80);
        beat(16'h1000, 1'b1, 16'h1000, 12'h000, 8'h00);
        beat(16'h3000, 1'b1, 16'h1000, 12'h000, 8'h00);
        drain();
        check("gain0_lo_cnt", {16'd0, clip_lo_cnt}, STATS ? 32'd1 : 32'd0);
        check("gain0_hi_cnt", {16'd0, clip_hi_cnt}, STATS ? 32'd1 : 32'd0);

        // 16-beat frame with a 5-cycle downstream stall
        fork
            begin
                for (int i = 1; i <= 16; i++)
                    beat(16'h1000 + 16'(i), i == 16, 16'h1000, g1[11:0], 8'(i));
                in_valid = 1'b0;
            end
            stall5();
        join
        drain();

        // Mid-frame gain change ignored; next frame picks it up
        beat(16'h1010, 1'b0, 16'h1000, g1[11:0], 8'h10);
        beat(16'h1020, 1'b0, 16'h1000, 12'h200, 8'h20);
        beat(16'h1030, 1'b0, 16'h1000, 12'h200, 8'h30);
        beat(16'h1040, 1'b1, 16'h1000, 12'h200, 8'h40);
        beat(16'h1010, 1'b0, 16'h1000, 12'h200, 8'h20);
        beat(16'h1020, 1'b1, 16'h1000, 12'h200, 8'h40);
        drain();

        // Reset with three samples in flight
        beat(16'h1800, 1'b0, 16'h1000, g1[11:0], 8'h00);
        beat(16'h1900, 1'b0, 16'h1000, g1[11:0], 8'h00);
        beat(16'h1A00, 1'b0, 16'h1000, g1[11:0], 8'h00);
        in_valid = 1'b0;
        reset    = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_lo_cnt", {16'd0, clip_lo_cnt}, 32'd0);
        check("midrst_hi_cnt", {16'd0, clip_hi_cnt}, 32'd0);
        reset = 1'b0;
        beat(16'h1100, 1'b1, 16'h1000, 12'h080, 8'h80);
        drain();
        check("final_hi_cnt", {16'd0, clip_hi_cnt}, 32'd0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/postproc_drc.md
# postproc_drc

Parametrised log-domain dynamic-range compressor for the envelope-detection chain, replacing the single-sample IDLE/COMPRESS/SEND post-processor with a fully pipelined, one-sample-per-cycle stage. It sits after the log-compression stage and feeds display/output formatting. Each sample is mapped as clamp(((log_in − floor) × gain) >>> GAIN_FRAC, 0, 2^COMP_WIDTH−1). Floor and gain are captured once per frame.

## Interface
- LOG_WIDTH, 16: width of unsigned log input.
- COMP_WIDTH, 8: width of compressed output.
- GAIN_WIDTH, 12: width of unsigned gain, fixed-point.
- GAIN_FRAC, 8: fractional bits of gain; gain of 1.0 = 2^GAIN_FRAC.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- log_in  in  LOG_WIDTH  log-magnitude sample.
- in_last  in  1  marks final sample of a frame.
- floor_cfg  in  LOG_WIDTH  dB floor, sampled on first beat of a frame.
- gain_cfg  in  GAIN_WIDTH  gain, sampled on first beat of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream ready.
- comp_out  out  COMP_WIDTH  compressed sample.
- out_last  out  1  in_last delayed with its sample.
- clip_lo_cnt  out  16  samples clamped to 0.
- clip_hi_cnt  out  16  samples clamped to maximum.

## Operation
- Three-stage pipeline.
  - S1: diff = {1'b0,log_in} − {1'b0,floor}, signed LOG_WIDTH+1. The sample's gain travels with it.
  - S2: prod = diff × gain, signed LOG_WIDTH+GAIN_WIDTH+1, exact, no truncation.
  - S3: sh = prod >>> GAIN_FRAC (arithmetic).
    - sh < 0 → comp_out = 0, clip_lo event.
    - sh > 2^COMP_WIDTH−1 → all-ones, clip_hi event.
    - Otherwise comp_out = sh[COMP_WIDTH−1:0].
- Frame tracking:
  - Internal first_beat flag is set by reset and by any accepted beat with in_last=1.
  - An accepted beat with first_beat=1 latches floor_cfg/gain_cfg into the frame registers, and that beat uses the new values.
  - The flag clears on any accepted beat with in_last=0.
  - Cfg changes mid-frame are ignored until the next frame.
  - Per-sample gain carry guarantees a frame boundary in flight never mixes configs.
- Each stage holds a valid bit. The pipeline advances when adv = !out_valid || out_ready. Every stage loads only on adv. Bubbles are carried, not collapsed.
- Reset values:
  - in_ready = 1, out_valid = 0, comp_out = 0, out_last = 0.
  - All stage valids = 0, counters = 0, first_beat = 1.
  - Frame floor/gain = 0.
- Reset mid-frame drops all in-flight samples. The next accepted beat is a first beat.

## Timing
- in_ready = adv, combinational from out_ready and out_valid. This is the only comb path input→output.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+3 when unstalled. Throughput is 1 sample/cycle.
- When out_valid && !out_ready, comp_out/out_last hold stable and in_ready=0.
- Clip events count at the edge where the S3 result is loaded into the output register.
- Counters saturate at 0xFFFF.
- in_valid=0 with adv=1 inserts a bubble. Gaps do not affect frame state.
- Simultaneous in_last beat and a new cfg: that beat uses the current frame config. The new cfg is taken at the next accepted beat.

## Configuration
- POSTPROC_CLIP_STATS_EN defined: clip_lo_cnt/clip_hi_cnt implemented as above.
- Undefined: counter logic omitted. Both ports are driven constant 0; the ports remain so instantiations are unchanged.

## Structure
- postproc_pkg:
  - Default width constants (LOG_WIDTH, COMP_WIDTH, GAIN_WIDTH, GAIN_FRAC).
  - GAIN_ONE = 1 << GAIN_FRAC.
  - CLIP_CNT_WIDTH = 16.
  - Stage-payload struct: data, gain, last, valid.
- Sub-module postproc_clamp: combinational S3 shift/clamp producing value, clip_lo, clip_hi. Instantiated once.

## Test plan
- floor=0x1000, gain=0x100, log_in=0x1050 → comp_out=0x50, 3 cycles later, no clips.
- Same cfg, log_in=0x0F00 → 0x00, clip_lo_cnt=1. log_in=0x2000 → 0xFF, clip_hi_cnt=1.
- gain=0x080 (0.5), floor=0x1000, log_in=0x1100 → 0x80. gain=0x000 → 0x00 for any input ≥ floor.
- Continuous stream 0x1001..0x1010 with out_ready low for 5 cycles mid-stream → all 16 outputs in order, none lost or duplicated. in_ready=0 during the stall, output held stable.
- Frame A (4 beats, gain 0x100) then frame B (gain 0x200), with gain_cfg changed during A's beat 2:
  - A uses 0x100 throughout.
  - B's first output doubles.
  - out_last is set on A beat 4 only.
- reset asserted with 3 samples in flight → next cycle out_valid=0, in_ready=1, counters 0. The next beat latches the new cfg.
